npu_data_mem: RTL and testbench
===============================

# npu_data_mem

Data-memory responder for the NPU convolution core: it serves the core's two per-cycle source/kernel read addresses with registered data and accepts its two result sums on completion. It also accepts a host-side streaming preload of image and kernel bytes. It sits between the host loader and the NPU core, owning the single 1024×8 scratchpad both sides share.

## Interface
- DATA_W, 8, width of one memory word and of each sum
- ADDR_W, 10, address width; depth is 2**ADDR_W words
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_rd_en  in  1  NPU read strobe
- i_rd_addr1  in  ADDR_W  NPU read address, port 1 (source/kernel)
- i_rd_addr2  in  ADDR_W  NPU read address, port 2 (source)
- o_rd_data1  out  DATA_W  registered read data, port 1
- o_rd_data2  out  DATA_W  registered read data, port 2
- i_npu_done  in  1  one-cycle pulse; sums and destination addresses valid
- i_sum1, i_sum2  in  DATA_W  result bytes
- i_dest_addr1, i_dest_addr2  in  ADDR_W  result destinations
- o_wb_done  out  1  one-cycle pulse after both sums are written
- i_load_start  in  1  begin host preload burst
- i_load_base  in  ADDR_W  first preload address, sampled with i_load_start
- i_load_valid  in  1  preload byte valid
- i_load_data  in  DATA_W  preload byte
- i_load_last  in  1  marks final byte of burst
- o_load_ready  out  1  memory accepts preload byte
- o_load_done  out  1  one-cycle pulse after last byte written
- o_busy  out  1  state is not IDLE

## Operation
- Storage: 2 asynchronous-address read ports, 1 write port; contents not reset.
- States: IDLE, LOAD, WB1, WB2.
- IDLE: i_npu_done → capture sums/addresses, go WB1. Else i_load_start → ptr=i_load_base, go LOAD. Both same cycle → i_npu_done wins; i_load_start dropped.
- LOAD: o_load_ready=1. Each valid&ready writes mem[ptr], ptr=ptr+1 mod 2**ADDR_W (1023 wraps to 0). Beat with i_load_last → pulse o_load_done next cycle, go IDLE (or WB1 if pending set). i_npu_done in LOAD → capture into pending registers; second done while pending overwrites it. i_load_start in LOAD ignored.
- WB1: write mem[dest1]=sum1, go WB2. WB2: write mem[dest2]=sum2, pulse o_wb_done, go IDLE. dest1==dest2 → sum2 final. i_npu_done/i_load_start in WB1/WB2 ignored.
- Reads: independent of state; i_rd_en=1 registers mem[addr] into o_rd_data*, i_rd_en=0 holds. Same address on both ports legal.
- Read of an address being written the same cycle returns old data unless bypass enabled.

## Timing
- Reset: state IDLE, o_rd_data1/2=0, o_wb_done=0, o_load_ready=0, o_load_done=0, o_busy=0, ptr=0, pending cleared.
- Read latency 1 cycle: address at edge N, data valid after edge N+1.
- Writeback: i_npu_done at edge N → sum1 written edge N+1, sum2 and o_wb_done asserted after edge N+2; o_wb_done high one cycle.
- o_load_ready combinational from state (high in LOAD only); first byte accepted cycle after i_load_start.
- o_load_done high for exactly the cycle after the last beat.
- i_rst mid-burst or mid-writeback: abort immediately, no further writes, pending discarded.

## Configuration
- NPU_MEM_RAW_BYPASS_EN defined: read whose address matches the same-cycle write address returns the write data (write-first), both ports.
- Undefined: read-first; returns pre-write contents.

## Structure
- Shared package npu_pkg: DATA_W/ADDR_W constants, state enum (IDLE, LOAD, WB1, WB2).
- One sub-module npu_mem_2r1w: storage array with two registered read ports, one write port, bypass logic under the macro. Top holds FSM, pointer, pending capture.

## Test plan
- Preload base 0x3FE, 4 bytes A1..A4 → mem[3FE]=A1, [3FF]=A2, [000]=A3, [001]=A4; o_load_done one cycle after last.
- Read addr1=0x3FF, addr2=0x000 with rd_en → next cycle o_rd_data1=A2, o_rd_data2=A3; rd_en low holds values.
- i_npu_done sum1=0x12@0x100, sum2=0x34@0x101 → o_wb_done 2 cycles later; readback 12/34.
- dest1=dest2=0x050, sums 0x11/0x22 → mem[050]=0x22.
- i_npu_done during LOAD burst → writeback runs immediately after o_load_done; o_wb_done 2 cycles after.
- Read 0x010 while load writes 0x010 same cycle → old value (new with NPU_MEM_RAW_BYPASS_EN); i_rst mid-burst → no further writes, outputs reset.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared constants and FSM state encoding for the NPU data-memory slice.
package npu_pkg;
   localparam int NPU_DATA_W = 8;
   localparam int NPU_ADDR_W = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WB1  = 2'd2,
      WB2  = 2'd3
   } state_e;
endpackage

// File: rtl/npu_mem_2r1w.sv
// Scratchpad storage: two registered read ports, one write port.
// NPU_MEM_RAW_BYPASS_EN selects write-first reads on an address collision; default is read-first.
module npu_mem_2r1w
   import npu_pkg::*;
#(
   parameter int DATA_W = NPU_DATA_W,
   parameter int ADDR_W = NPU_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr1,
   input  logic [ADDR_W-1:0] i_rd_addr2,
   output logic [DATA_W-1:0] o_rd_data1,
   output logic [DATA_W-1:0] o_rd_data2,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata
);
   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rd_data1_d, rd_data1_q;
   logic [DATA_W-1:0] rd_data2_d, rd_data2_q;

   always_comb begin
      rd_data1_d = rd_data1_q;
      rd_data2_d = rd_data2_q;
      if (i_rd_en) begin
         rd_data1_d = mem_q[i_rd_addr1];
         rd_data2_d = mem_q[i_rd_addr2];
`ifdef NPU_MEM_RAW_BYPASS_EN
         if (i_we && (i_waddr == i_rd_addr1)) rd_data1_d = i_wdata;
         if (i_we && (i_waddr == i_rd_addr2)) rd_data2_d = i_wdata;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_data1_q <= '0;
         rd_data2_q <= '0;
      end else begin
         rd_data1_q <= rd_data1_d;
         rd_data2_q <= rd_data2_d;
      end
   end

   // Array contents are intentionally left unreset.
   always_ff @(posedge i_clk) begin
      if (i_we) mem_q[i_waddr] <= i_wdata;
   end

   assign o_rd_data1 = rd_data1_q;
   assign o_rd_data2 = rd_data2_q;
endmodule

// File: rtl/npu_data_mem.sv
// NPU data-memory responder: host preload bursts, NPU reads and two-sum writeback.
// Build option NPU_MEM_RAW_BYPASS_EN is handled inside npu_mem_2r1w.
//
// state | meaning
// IDLE  | waiting for i_npu_done or i_load_start
// LOAD  | accepting preload bytes at ptr; i_npu_done is parked as pending
// WB1   | writing sum1 to dest1
// WB2   | writing sum2 to dest2, pulsing o_wb_done
module npu_data_mem
   import npu_pkg::*;
#(
   parameter int DATA_W = NPU_DATA_W,
   parameter int ADDR_W = NPU_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr1,
   input  logic [ADDR_W-1:0] i_rd_addr2,
   output logic [DATA_W-1:0] o_rd_data1,
   output logic [DATA_W-1:0] o_rd_data2,
   input  logic              i_npu_done,
   input  logic [DATA_W-1:0] i_sum1,
   input  logic [DATA_W-1:0] i_sum2,
   input  logic [ADDR_W-1:0] i_dest_addr1,
   input  logic [ADDR_W-1:0] i_dest_addr2,
   output logic              o_wb_done,
   input  logic              i_load_start,
   input  logic [ADDR_W-1:0] i_load_base,
   input  logic              i_load_valid,
   input  logic [DATA_W-1:0] i_load_data,
   input  logic              i_load_last,
   output logic              o_load_ready,
   output logic              o_load_done,
   output logic              o_busy
);
   state_e            state_d, state_q;
   logic [ADDR_W-1:0] ptr_d, ptr_q;
   logic [DATA_W-1:0] sum1_d, sum1_q, sum2_d, sum2_q;
   logic [ADDR_W-1:0] dest1_d, dest1_q, dest2_d, dest2_q;
   logic              pend_d, pend_q;
   logic              wb_done_d, wb_done_q;
   logic              load_done_d, load_done_q;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sum1_d      = sum1_q;
      sum2_d      = sum2_q;
      dest1_d     = dest1_q;
      dest2_d     = dest2_q;
      pend_d      = pend_q;
      wb_done_d   = 1'b0;
      load_done_d = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = ptr_q;
      wr_data     = i_load_data;
      case (state_q)
         IDLE: begin
            if (i_npu_done) begin
               sum1_d  = i_sum1;
               sum2_d  = i_sum2;
               dest1_d = i_dest_addr1;
               dest2_d = i_dest_addr2;
               state_d = WB1;
            end else if (i_load_start) begin
               ptr_d   = i_load_base;
               state_d = LOAD;
            end
         end
         LOAD: begin
            // A later done simply overwrites the parked one.
            if (i_npu_done) begin
               sum1_d  = i_sum1;
               sum2_d  = i_sum2;
               dest1_d = i_dest_addr1;
               dest2_d = i_dest_addr2;
               pend_d  = 1'b1;
            end
            if (i_load_valid) begin
               wr_en = 1'b1;
               ptr_d = ptr_q + 1'b1;
               if (i_load_last) begin
                  load_done_d = 1'b1;
                  pend_d      = 1'b0;
                  state_d     = (pend_q || i_npu_done) ? WB1 : IDLE;
               end
            end
         end
         WB1: begin
            wr_en   = 1'b1;
            wr_addr = dest1_q;
            wr_data = sum1_q;
            state_d = WB2;
         end
         WB2: begin
            wr_en     = 1'b1;
            wr_addr   = dest2_q;
            wr_data   = sum2_q;
            wb_done_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         sum1_q      <= '0;
         sum2_q      <= '0;
         dest1_q     <= '0;
         dest2_q     <= '0;
         pend_q      <= 1'b0;
         wb_done_q   <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sum1_q      <= sum1_d;
         sum2_q      <= sum2_d;
         dest1_q     <= dest1_d;
         dest2_q     <= dest2_d;
         pend_q      <= pend_d;
         wb_done_q   <= wb_done_d;
         load_done_q <= load_done_d;
      end
   end

   // Reset must block the write that the current state would otherwise issue.
   npu_mem_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_rd_en    (i_rd_en),
      .i_rd_addr1 (i_rd_addr1),
      .i_rd_addr2 (i_rd_addr2),
      .o_rd_data1 (o_rd_data1),
      .o_rd_data2 (o_rd_data2),
      .i_we       (wr_en && !i_rst),
      .i_waddr    (wr_addr),
      .i_wdata    (wr_data)
   );

   assign o_wb_done    = wb_done_q;
   assign o_load_done  = load_done_q;
   assign o_load_ready = (state_q == LOAD);
   assign o_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_npu_data_mem.sv
// Scoreboard bench for npu_data_mem: directed preload, read, writeback and reset scenarios.
module tb_npu_data_mem;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rd_en = 1'b0;
   logic [9:0] rd_addr1 = '0, rd_addr2 = '0;
   logic [7:0] rd_data1, rd_data2;
   logic       npu_done = 1'b0;
   logic [7:0] sum1 = '0, sum2 = '0;
   logic [9:0] dest1 = '0, dest2 = '0;
   logic       wb_done;
   logic       load_start = 1'b0;
   logic [9:0] load_base = '0;
   logic       load_valid = 1'b0;
   logic [7:0] load_data = '0;
   logic       load_last = 1'b0;
   logic       load_ready, load_done, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic rd_v = 1'b0;
   logic rst_v = 1'b0;
   logic [15:0] rd_q[$];
   int wb_q[$];
   int ld_q[$];
   logic [15:0] last_rd = '0;

   npu_data_mem dut (
      .i_clk(clk), .i_rst(rst),
      .i_rd_en(rd_en), .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
      .o_rd_data1(rd_data1), .o_rd_data2(rd_data2),
      .i_npu_done(npu_done), .i_sum1(sum1), .i_sum2(sum2),
      .i_dest_addr1(dest1), .i_dest_addr2(dest2), .o_wb_done(wb_done),
      .i_load_start(load_start), .i_load_base(load_base),
      .i_load_valid(load_valid), .i_load_data(load_data), .i_load_last(load_last),
      .o_load_ready(load_ready), .o_load_done(load_done), .o_busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rd_v  <= rd_en;
      rst_v <= rst;
   end

   // Monitor: pulses are matched against expected cycles, read data against queued values.
   always @(negedge clk) begin
      int e;
      logic [15:0] r;
      if (cyc > 0) begin
         if (wb_done) begin
            checks++;
            if (wb_q.size() == 0) begin
               errors++;
               $display("FAIL wb_done: unexpected pulse at cycle %0d", cyc);
            end else begin
               e = wb_q.pop_front();
               if (e != cyc) begin
                  errors++;
                  $display("FAIL wb_done: pulse at cycle %0d, required %0d", cyc, e);
               end
            end
         end
         if (load_done) begin
            checks++;
            if (ld_q.size() == 0) begin
               errors++;
               $display("FAIL load_done: unexpected pulse at cycle %0d", cyc);
            end else begin
               e = ld_q.pop_front();
               if (e != cyc) begin
                  errors++;
                  $display("FAIL load_done: pulse at cycle %0d, required %0d", cyc, e);
               end
            end
         end
         r = last_rd;
         if (rst_v) r = 16'h0000;
         else if (rd_v) begin
            if (rd_q.size() == 0) begin
               errors++;
               $display("FAIL rd_data: no expected entry at cycle %0d", cyc);
            end else r = rd_q.pop_front();
         end
         last_rd = r;
         checks++;
         if ({rd_data1, rd_data2} !== r) begin
            errors++;
            $display("FAIL rd_data: cycle %0d got %h/%h, required %h/%h",
                     cyc, rd_data1, rd_data2, r[15:8], r[7:0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic do_read(input logic [9:0] a1, input logic [9:0] a2,
                          input logic [7:0] e1, input logic [7:0] e2);
      rd_en = 1'b1;
      rd_addr1 = a1;
      rd_addr2 = a2;
      rd_q.push_back({e1, e2});
      tick();
      rd_en = 1'b0;
   endtask

   task automatic load_burst(input logic [9:0] base, input logic [31:0] bytes, input int n);
      load_start = 1'b1;
      load_base = base;
      chk("ready_idle", {31'd0, load_ready}, 32'd0);
      tick();
      load_start = 1'b0;
      chk("ready_load", {31'd0, load_ready}, 32'd1);
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data = bytes[8*i +: 8];
         load_last = (i == n - 1);
         if (i == n - 1) ld_q.push_back(cyc + 1);
         tick();
      end
      load_valid = 1'b0;
      load_last = 1'b0;
      tick();
   endtask

   task automatic npu_wb(input logic [7:0] s1, input logic [9:0] d1,
                         input logic [7:0] s2, input logic [9:0] d2);
      npu_done = 1'b1;
      sum1 = s1; dest1 = d1; sum2 = s2; dest2 = d2;
      wb_q.push_back(cyc + 3);
      tick();
      npu_done = 1'b0;
      chk("busy_wb", {31'd0, busy}, 32'd1);
      repeat (3) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, load_ready}, 32'd0);
      chk("rst_wb_done", {31'd0, wb_done}, 32'd0);
      chk("rst_load_done", {31'd0, load_done}, 32'd0);
      rst = 1'b0;
      tick();

      // Wrapping preload and reads across the 3FF/000 boundary.
      load_burst(10'h3FE, 32'hA4A3A2A1, 4);
      do_read(10'h3FF, 10'h000, 8'hA2, 8'hA3);
      do_read(10'h3FE, 10'h001, 8'hA1, 8'hA4);
      repeat (2) tick();

      npu_wb(8'h12, 10'h100, 8'h34, 10'h101);
      do_read(10'h100, 10'h101, 8'h12, 8'h34);
      npu_wb(8'h11, 10'h050, 8'h22, 10'h050);
      do_read(10'h050, 10'h050, 8'h22, 8'h22);

      // Done arriving mid-burst is held until the burst closes.
      load_start = 1'b1; load_base = 10'h200;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 8'hB1;
      tick();
      load_data = 8'hB2;
      npu_done = 1'b1; sum1 = 8'h55; dest1 = 10'h300; sum2 = 8'h66; dest2 = 10'h301;
      tick();
      npu_done = 1'b0;
      load_data = 8'hB3; load_last = 1'b1;
      ld_q.push_back(cyc + 1);
      wb_q.push_back(cyc + 3);
      tick();
      load_valid = 1'b0; load_last = 1'b0;
      repeat (4) tick();
      do_read(10'h200, 10'h201, 8'hB1, 8'hB2);
      do_read(10'h202, 10'h300, 8'hB3, 8'h55);
      do_read(10'h301, 10'h300, 8'h66, 8'h55);

      // Done and load start together: done wins, start is dropped.
      npu_done = 1'b1; sum1 = 8'h77; dest1 = 10'h060; sum2 = 8'h78; dest2 = 10'h061;
      load_start = 1'b1; load_base = 10'h070;
      wb_q.push_back(cyc + 3);
      tick();
      npu_done = 1'b0; load_start = 1'b0;
      chk("ready_in_wb", {31'd0, load_ready}, 32'd0);
      repeat (3) tick();
      chk("ready_after_wb", {31'd0, load_ready}, 32'd0);
      chk("busy_after_wb", {31'd0, busy}, 32'd0);
      do_read(10'h060, 10'h061, 8'h77, 8'h78);

      // Same-cycle read of the address being written.
      load_burst(10'h010, 32'h0000005A, 1);
      load_start = 1'b1; load_base = 10'h010;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 8'hC3; load_last = 1'b1;
      ld_q.push_back(cyc + 1);
`ifdef NPU_MEM_RAW_BYPASS_EN
      do_read(10'h010, 10'h010, 8'hC3, 8'hC3);
`else
      do_read(10'h010, 10'h010, 8'h5A, 8'h5A);
`endif
      load_valid = 1'b0; load_last = 1'b0;
      tick();
      do_read(10'h010, 10'h010, 8'hC3, 8'hC3);

      // Reset mid-burst: the beat coinciding with reset must not land.
      load_burst(10'h020, 32'h00007170, 2);
      load_start = 1'b1; load_base = 10'h020;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 8'hE0;
      tick();
      load_data = 8'hE1; rst = 1'b1;
      tick();
      rst = 1'b0; load_valid = 1'b0;
      chk("rst_burst_busy", {31'd0, busy}, 32'd0);
      chk("rst_burst_ready", {31'd0, load_ready}, 32'd0);
      tick();
      do_read(10'h020, 10'h021, 8'hE0, 8'h71);

      // Reset mid-writeback: neither sum is written, no wb_done.
      load_burst(10'h030, 32'h00004140, 2);
      npu_done = 1'b1; sum1 = 8'h99; dest1 = 10'h030; sum2 = 8'h9A; dest2 = 10'h031;
      tick();
      npu_done = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_wb_busy", {31'd0, busy}, 32'd0);
      repeat (3) tick();
      do_read(10'h030, 10'h031, 8'h40, 8'h41);

      repeat (4) tick();
      chk("rd_queue_empty", rd_q.size(), 32'd0);
      chk("wb_queue_empty", wb_q.size(), 32'd0);
      chk("ld_queue_empty", ld_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
